// File: rtl/vec_pkg.sv
// vec_pkg: shared types for the vector register write path.
//   VEC_WIDTH / LANE_WIDTH / NUM_LANES describe the 256-bit vector (8 lanes of 32 bits,
//   lane i at bits [32i+31:32i]); VREG_IDX_W is the register-file index width.
//   vec_wr_entry_t is one buffered commit: destination index plus vector data.
package vec_pkg;

    localparam int VEC_WIDTH  = 256;
    localparam int LANE_WIDTH = 32;
    localparam int NUM_LANES  = 8;
    localparam int VREG_IDX_W = 2;

    typedef logic [VEC_WIDTH-1:0]  vec_t;
    typedef logic [VREG_IDX_W-1:0] vreg_idx_t;

    typedef struct packed {
        vreg_idx_t idx;
        vec_t      data;
    } vec_wr_entry_t;

endpackage

// File: rtl/vec_fifo.sv
// vec_fifo: generic synchronous FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and entry; accepted when !full, or when full and a pop
//                is accepted in the same cycle
//   pop        : read request; accepted when !empty, advances the head at the edge
//   dout       : head entry (registered storage, valid while !empty)
//   full/empty : occupancy flags; count is the current occupancy (0..DEPTH)
module vec_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vec_write_buffer.sv
// vec_write_buffer: collapses the vector assembler's level commit strobe into single
// commits, queues them, and drains them into the vector register file.
//   clk, rst           : clock, synchronous active-high reset
//   vecWrite, vecAddr  : commit strobe (level) and destination register index (16 bits)
//   vector             : assembled 256-bit vector
//   vr_wr_req/addr/data: head entry toward the register file
//   vr_wr_ack          : register file accepted the head this cycle
//   full, count        : FIFO occupancy
//   err_ovf, err_addr  : sticky drop flags (FIFO full / index out of range), cleared by rst
//
// Register-file handshake: vr_wr_req is a valid, vr_wr_ack a ready. An entry transfers on
// the edge where both are high; while req is high and ack low, addr/data hold steady.
// Ack while req is low has no effect. All outputs come from registers.
module vec_write_buffer
    import vec_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_VREGS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vecWrite,
    input  logic [15:0]             vecAddr,
    input  logic [255:0]            vector,
    output logic                    vr_wr_req,
    output logic [1:0]              vr_wr_addr,
    output logic [255:0]            vr_wr_data,
    input  logic                    vr_wr_ack,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_ovf,
    output logic                    err_addr
);

    localparam logic [15:0] NUM_VREGS_W = 16'(NUM_VREGS);

    logic           prev_write;
    logic [15:0]    prev_addr;
    logic           new_commit;
    logic           addr_ok;
    logic           legal_commit;
    logic           do_pop;
    logic           do_push;
    logic           ovf_drop;
    logic           empty;
    vec_wr_entry_t  din;
    vec_wr_entry_t  head;

    // The assembler holds the strobe while its address sits on the commit location,
    // so only a rising strobe or an address change under the strobe is a new commit.
    assign new_commit   = vecWrite && !(prev_write && (vecAddr == prev_addr));
    // Full 16-bit compare: an index like 16'h0100 must not alias to register 0.
    assign addr_ok      = (vecAddr < NUM_VREGS_W);
    assign legal_commit = new_commit && addr_ok;

    assign do_pop   = vr_wr_req && vr_wr_ack;
    assign do_push  = legal_commit && (!full || do_pop);
    assign ovf_drop = legal_commit && full && !do_pop;

    assign din.idx  = vecAddr[1:0];
    assign din.data = vector;

    vec_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (vec_wr_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign vr_wr_req  = !empty;
    assign vr_wr_addr = head.idx;
    assign vr_wr_data = head.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_write <= 1'b0;
            prev_addr  <= '0;
            err_ovf    <= 1'b0;
            err_addr   <= 1'b0;
        end else begin
            prev_write <= vecWrite;
            prev_addr  <= vecAddr;
            if (new_commit && !addr_ok) begin
                err_addr <= 1'b1;
            end
            if (ovf_drop) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule
